// File: rtl/geo_clip_sequencer.sv
// geo_clip_sequencer
//   Accepts one clip-space triangle, clips it against up to NUM_PLANES planes
//   in index order through one external clipper, and streams the surviving
//   triangles to the rasteriser. Two triangle buffers alternate as
//   source/destination; each enabled plane consumes the source buffer and
//   refills the destination buffer, then the roles swap.
//
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   in_valid_i/in_ready_o input triangle handshake (ready only while idle)
//   in_tri_i              packed triangle {v2.wzyx, v1.wzyx, v0.wzyx}
//   in_plane_en_i         per-triangle plane enable mask, latched on accept
//   clip_req_*            request to the clipper: triangle + plane index
//   clip_rsp_*            clipper result: 0..2 triangles, single-cycle pulse
//   out_valid_o/out_ready_i output triangle handshake
//   out_tri_o, out_last_o, out_count_o  triangle, last-of-batch, batch size
//   busy_o                batch in progress
//   overflow_o            sticky: results dropped for the current triangle
//   done_o                one-cycle pulse when a batch completes
module geo_clip_sequencer #(
  parameter int VERTEX_WIDTH = 32,
  parameter int NUM_PLANES   = 6,
  parameter int MAX_TRIS     = 16,
  parameter int TRI_W        = 12*VERTEX_WIDTH
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              in_valid_i,
  output logic                              in_ready_o,
  input  logic [TRI_W-1:0]                  in_tri_i,
  input  logic [NUM_PLANES-1:0]             in_plane_en_i,
  output logic                              clip_req_valid_o,
  input  logic                              clip_req_ready_i,
  output logic [TRI_W-1:0]                  clip_tri_o,
  output logic [$clog2(NUM_PLANES+1)-1:0]   clip_plane_o,
  input  logic                              clip_rsp_valid_i,
  input  logic [1:0]                        clip_rsp_count_i,
  input  logic [TRI_W-1:0]                  clip_rsp_tri0_i,
  input  logic [TRI_W-1:0]                  clip_rsp_tri1_i,
  output logic                              out_valid_o,
  input  logic                              out_ready_i,
  output logic [TRI_W-1:0]                  out_tri_o,
  output logic                              out_last_o,
  output logic [$clog2(MAX_TRIS+1)-1:0]     out_count_o,
  output logic                              busy_o,
  output logic                              overflow_o,
  output logic                              done_o
);

  localparam int PW = $clog2(NUM_PLANES+1);
  localparam int CW = $clog2(MAX_TRIS+1);
  localparam int IW = $clog2(MAX_TRIS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_CLIP_REQ,
    S_CLIP_WAIT,
    S_EMIT
  } state_t;

  state_t                state_q, state_d;
  logic [PW-1:0]         plane_q;
  logic [CW-1:0]         rd_idx_q;
  logic [CW-1:0]         wr_cnt_q;
  logic [CW-1:0]         count_q;
  logic                  sel_q;
  logic                  overflow_q;
  logic                  done_q;
  logic [NUM_PLANES-1:0] mask_q;

  // Ping-pong storage: tri_buf[sel_q] is the source, tri_buf[~sel_q] the destination.
  logic [TRI_W-1:0] tri_buf [2][MAX_TRIS];
  logic [TRI_W-1:0] src_tri;

  logic          plane_on;
  logic          scan_end;
  logic          last_rd;
  logic          accept;
  logic          rsp_take;
  logic [1:0]    rsp_n;
  logic          ok0, ok1, drop;
  logic [CW-1:0] idx1;
  logic [CW-1:0] wr_cnt_nxt;

  assign src_tri  = tri_buf[sel_q][rd_idx_q[IW-1:0]];
  assign last_rd  = ((rd_idx_q + CW'(1)) == count_q);
  assign scan_end = (plane_q == PW'(NUM_PLANES)) || (count_q == '0);
  assign accept   = (state_q == S_IDLE) && in_valid_i;
  assign rsp_take = (state_q == S_CLIP_WAIT) && clip_rsp_valid_i;

  always_comb begin
    plane_on = 1'b0;
    for (int unsigned i = 0; i < NUM_PLANES; i++) begin
      if (plane_q == PW'(i)) plane_on = mask_q[i];
    end
  end

  // Result placement: tri1 lands right after tri0 only if tri0 was kept, so
  // once the destination is full every further result is dropped and
  // wr_cnt stops at MAX_TRIS.
  always_comb begin
    case (clip_rsp_count_i)
      2'd0:    rsp_n = 2'd0;
      2'd1:    rsp_n = 2'd1;
      default: rsp_n = 2'd2;
    endcase
    ok0        = (rsp_n != 2'd0) && (wr_cnt_q < CW'(MAX_TRIS));
    idx1       = wr_cnt_q + CW'(ok0);
    ok1        = (rsp_n == 2'd2) && (idx1 < CW'(MAX_TRIS));
    drop       = ((rsp_n != 2'd0) && !ok0) || ((rsp_n == 2'd2) && !ok1);
    wr_cnt_nxt = idx1 + CW'(ok1);
  end

  always_comb begin
    state_d          = state_q;
    in_ready_o       = 1'b0;
    clip_req_valid_o = 1'b0;
    clip_tri_o       = '0;
    clip_plane_o     = '0;
    out_valid_o      = 1'b0;
    out_tri_o        = '0;
    out_last_o       = 1'b0;
    case (state_q)
      S_IDLE: begin
        in_ready_o = 1'b1;
        if (in_valid_i) state_d = S_SCAN;
      end
      S_SCAN: begin
        if (scan_end)      state_d = S_EMIT;
        else if (plane_on) state_d = S_CLIP_REQ;
      end
      S_CLIP_REQ: begin
        clip_req_valid_o = 1'b1;
        clip_tri_o       = src_tri;
        clip_plane_o     = plane_q;
        if (clip_req_ready_i) state_d = S_CLIP_WAIT;
      end
      S_CLIP_WAIT: begin
        if (clip_rsp_valid_i) state_d = last_rd ? S_SCAN : S_CLIP_REQ;
      end
      S_EMIT: begin
        if (count_q == '0) begin
          state_d = S_IDLE;
        end else begin
          out_valid_o = 1'b1;
          out_tri_o   = src_tri;
          out_last_o  = last_rd;
          if (out_ready_i && last_rd) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign out_count_o = count_q;
  assign busy_o      = (state_q != S_IDLE);
  assign overflow_o  = overflow_q;
  assign done_o      = done_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      plane_q    <= '0;
      rd_idx_q   <= '0;
      wr_cnt_q   <= '0;
      count_q    <= '0;
      sel_q      <= 1'b0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
      mask_q     <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (in_valid_i) begin
            count_q    <= CW'(1);
            mask_q     <= in_plane_en_i;
            plane_q    <= '0;
            overflow_q <= 1'b0;
          end
        end
        S_SCAN: begin
          if (scan_end) begin
            rd_idx_q <= '0;
          end else if (!plane_on) begin
            plane_q <= plane_q + PW'(1);
          end else begin
            rd_idx_q <= '0;
            wr_cnt_q <= '0;
          end
        end
        S_CLIP_WAIT: begin
          if (clip_rsp_valid_i) begin
            wr_cnt_q <= wr_cnt_nxt;
            if (drop) overflow_q <= 1'b1;
            if (last_rd) begin
              sel_q   <= ~sel_q;
              count_q <= wr_cnt_nxt;
              plane_q <= plane_q + PW'(1);
            end else begin
              rd_idx_q <= rd_idx_q + CW'(1);
            end
          end
        end
        S_EMIT: begin
          if (count_q == '0) begin
            done_q <= 1'b1;
          end else if (out_ready_i) begin
            if (last_rd) done_q <= 1'b1;
            else         rd_idx_q <= rd_idx_q + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (accept) tri_buf[sel_q][0] <= in_tri_i;
      if (rsp_take) begin
        if (ok0) tri_buf[~sel_q][wr_cnt_q[IW-1:0]] <= clip_rsp_tri0_i;
        if (ok1) tri_buf[~sel_q][idx1[IW-1:0]]     <= clip_rsp_tri1_i;
      end
    end
  end

endmodule
